// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: multi-cycle sequencer for the RV64 core datapath.
// Steps fetch/decode/execute/memory/writeback, owns the fetch and LSU
// handshakes, stops on ebreak, wait timeouts or illegal instructions, and
// keeps the cycle/instret counters.
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | ifu_req high, waiting for ifu_rvalid (bounded by TIMEOUT)
// DECODE  | classify the held IR: error, halt or execute
// EXEC    | single execute cycle, choose MEM or WB
// MEM     | lsu_req high, waiting for lsu_done (bounded by TIMEOUT)
// WB      | register-file / PC update, instruction retires
// HALT    | stopped by ebreak until reset
// ERROR   | stopped by timeout or illegal instruction until reset
module core_seq_ctrl #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             ifu_req,
   input  logic             ifu_rvalid,
   output logic             ir_we,
   input  logic             dec_load,
   input  logic             dec_store,
   input  logic             dec_wb,
   input  logic             dec_ebreak,
   input  logic             dec_illegal,
   output logic             lsu_req,
   output logic             lsu_wen,
   input  logic             lsu_done,
   output logic             rf_we,
   output logic             pc_we,
   output logic             halt,
   output logic             err,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;
   localparam logic [2:0] S_HALT   = 3'd6;
   localparam logic [2:0] S_ERROR  = 3'd7;

   localparam logic [15:0]      WAIT_LIMIT = 16'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   logic [2:0]  state_q;
   logic [2:0]  state_d;
   logic [15:0] wait_cnt;
   logic        wait_expired;
   logic        is_active;
   logic        retire;
   logic        enter_wait;

   assign wait_expired = (wait_cnt == WAIT_LIMIT);
   assign is_active    = (state_q >= S_FETCH) && (state_q <= S_WB);
   // ebreak retires in DECODE; everything else retires in WB
   assign retire       = (state_q == S_WB) ||
                         ((state_q == S_DECODE) && (state_d == S_HALT));
   assign enter_wait   = (state_d != state_q) &&
                         ((state_d == S_FETCH) || (state_d == S_MEM));

   // Next-state selection; a handshake on the timeout cycle beats the timeout
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start) state_d = S_FETCH;
         S_FETCH: begin
            if (ifu_rvalid)        state_d = S_DECODE;
            else if (wait_expired) state_d = S_ERROR;
         end
         S_DECODE: begin
            if (dec_illegal || (dec_load && dec_store)) state_d = S_ERROR;
            else if (dec_ebreak)                        state_d = S_HALT;
            else                                        state_d = S_EXEC;
         end
         S_EXEC:   state_d = (dec_load || dec_store) ? S_MEM : S_WB;
         S_MEM: begin
            if (lsu_done)          state_d = S_WB;
            else if (wait_expired) state_d = S_ERROR;
         end
         S_WB:     state_d = S_FETCH;
         default:  state_d = state_q;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Wait counter for FETCH/MEM, restarted on each entry to a wait state
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                            wait_cnt <= '0;
      else if (enter_wait)                                wait_cnt <= '0;
      else if ((state_q == S_FETCH) || (state_q == S_MEM)) wait_cnt <= wait_cnt + 16'd1;
   end

   // Performance counters, wrapping silently
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else begin
         if (is_active) cycle_cnt   <= cycle_cnt + CNT_ONE;
         if (retire)    instret_cnt <= instret_cnt + CNT_ONE;
      end
   end

   assign state   = state_q;
   assign ifu_req = (state_q == S_FETCH);
   assign ir_we   = (state_q == S_FETCH) && ifu_rvalid;
   assign lsu_req = (state_q == S_MEM);
   assign lsu_wen = (state_q == S_MEM) && dec_store;
   assign rf_we   = (state_q == S_WB) && dec_wb && !dec_store;
   assign pc_we   = (state_q == S_WB);
   assign halt    = (state_q == S_HALT);
   assign err     = (state_q == S_ERROR);

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Bench for core_seq_ctrl: directed scenarios plus a randomized instruction
// stream checked against an expected per-instruction state trace.
module tb_core_seq_ctrl;

   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        ifu_req;
   logic        ifu_rvalid;
   logic        ir_we;
   logic        dec_load;
   logic        dec_store;
   logic        dec_wb;
   logic        dec_ebreak;
   logic        dec_illegal;
   logic        lsu_req;
   logic        lsu_wen;
   logic        lsu_done;
   logic        rf_we;
   logic        pc_we;
   logic        halt;
   logic        err;
   logic [2:0]  state;
   logic [63:0] cycle_cnt;
   logic [63:0] instret_cnt;

   int          total = 0;
   int          bad   = 0;
   logic [63:0] m_cyc;
   logic [63:0] m_ret;

   core_seq_ctrl #(.TIMEOUT(TO), .CNT_W(64)) dut (
      .clk(clk), .rst(rst), .start(start),
      .ifu_req(ifu_req), .ifu_rvalid(ifu_rvalid), .ir_we(ir_we),
      .dec_load(dec_load), .dec_store(dec_store), .dec_wb(dec_wb),
      .dec_ebreak(dec_ebreak), .dec_illegal(dec_illegal),
      .lsu_req(lsu_req), .lsu_wen(lsu_wen), .lsu_done(lsu_done),
      .rf_we(rf_we), .pc_we(pc_we), .halt(halt), .err(err),
      .state(state), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
   );

   always #5 clk = ~clk;

   // output strobes packed as {ifu_req, ir_we, lsu_req, lsu_wen, rf_we, pc_we, halt, err}
   function automatic logic [7:0] flags();
      return {ifu_req, ir_we, lsu_req, lsu_wen, rf_we, pc_we, halt, err};
   endfunction

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; ifu_rvalid = 1'b0; lsu_done = 1'b0;
      dec_load = 1'b0; dec_store = 1'b0; dec_wb = 1'b0;
      dec_ebreak = 1'b0; dec_illegal = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      m_cyc = '0; m_ret = '0;
   endtask

   task automatic kick();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Runs one instruction and checks every cycle against the expected trace.
   // cls: 0 ALU, 1 load, 2 store; fd/md: extra wait cycles before the handshake.
   task automatic run_instr(input int cls, input int fd, input int md, input bit wb);
      logic [2:0] q[$];
      logic [2:0] s;
      logic [7:0] ef;
      bit         lf, lm;
      dec_load = (cls == 1); dec_store = (cls == 2); dec_wb = wb;
      dec_ebreak = 1'b0; dec_illegal = 1'b0;
      for (int i = 0; i <= fd; i++) q.push_back(3'd1);
      q.push_back(3'd2);
      q.push_back(3'd3);
      if (cls != 0) for (int i = 0; i <= md; i++) q.push_back(3'd4);
      q.push_back(3'd5);
      for (int k = 0; k < q.size(); k++) begin
         s  = q[k];
         lf = (s == 3'd1) && (k == fd);
         lm = (s == 3'd4) && (k == fd + 3 + md);
         ifu_rvalid = lf;
         lsu_done   = lm;
         #1;
         ef = {s == 3'd1, lf, s == 3'd4, (s == 3'd4) && (cls == 2),
               (s == 3'd5) && wb && (cls != 2), s == 3'd5, 1'b0, 1'b0};
         total++;
         if (state !== s) begin
            bad++; $display("FAIL instr_state k=%0d: got %0d expected %0d", k, state, s);
         end
         total++;
         if (flags() !== ef) begin
            bad++; $display("FAIL instr_flags k=%0d st=%0d: got %b expected %b", k, s, flags(), ef);
         end
         @(posedge clk); #1;
         ifu_rvalid = 1'b0; lsu_done = 1'b0;
      end
      m_cyc += 64'(q.size());
      m_ret += 64'd1;
      total++;
      if ({cycle_cnt, instret_cnt} !== {m_cyc, m_ret}) begin
         bad++; $display("FAIL instr_counters: got cyc=%0d ret=%0d expected cyc=%0d ret=%0d",
                         cycle_cnt, instret_cnt, m_cyc, m_ret);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; ifu_rvalid = 1'b1; lsu_done = 1'b1;
      #3;
      total++;
      if (state !== 3'd0 || flags() !== 8'h00) begin
         bad++; $display("FAIL reset_outputs: got state=%0d flags=%b expected 0/00000000", state, flags());
      end
      total++;
      if (cycle_cnt !== 64'd0 || instret_cnt !== 64'd0) begin
         bad++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", cycle_cnt, instret_cnt);
      end
      do_reset();
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (state !== 3'd0 || cycle_cnt !== 64'd0) begin
         bad++; $display("FAIL idle_hold: got state=%0d cyc=%0d expected 0/0", state, cycle_cnt);
      end
   endtask

   task automatic test_addi();
      do_reset();
      kick();
      total++;
      if (state !== 3'd1) begin
         bad++; $display("FAIL start_to_fetch: got %0d expected 1", state);
      end
      run_instr(0, 0, 0, 1'b1);
      total++;
      if (state !== 3'd1 || cycle_cnt !== 64'd4 || instret_cnt !== 64'd1) begin
         bad++; $display("FAIL addi_summary: got st=%0d cyc=%0d ret=%0d expected 1/4/1",
                         state, cycle_cnt, instret_cnt);
      end
   endtask

   task automatic test_load_store();
      do_reset();
      kick();
      run_instr(1, 0, 3, 1'b1);
      total++;
      if (cycle_cnt !== 64'd8) begin
         bad++; $display("FAIL load_delay_cycles: got %0d expected 8", cycle_cnt);
      end
      run_instr(2, 0, 0, 1'b1);
      total++;
      if (cycle_cnt !== 64'd13 || instret_cnt !== 64'd2) begin
         bad++; $display("FAIL store_cycles: got %0d/%0d expected 13/2", cycle_cnt, instret_cnt);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      kick();
      for (int c = 0; c < 5; c++) begin
         ifu_rvalid = 1'b0;
         #1;
         total++;
         if (state !== 3'd1 || ifu_req !== 1'b1) begin
            bad++; $display("FAIL fetch_wait c=%0d: got st=%0d req=%b expected 1/1", c, state, ifu_req);
         end
         @(posedge clk); #1;
      end
      total++;
      if (state !== 3'd7 || flags() !== 8'b0000_0001 || cycle_cnt !== 64'd5) begin
         bad++; $display("FAIL fetch_timeout: got st=%0d flags=%b cyc=%0d expected 7/00000001/5",
                         state, flags(), cycle_cnt);
      end
      ifu_rvalid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (state !== 3'd7 || ir_we !== 1'b0 || cycle_cnt !== 64'd5) begin
         bad++; $display("FAIL error_sticky: got st=%0d ir_we=%b cyc=%0d expected 7/0/5",
                         state, ir_we, cycle_cnt);
      end
      // handshake on the timeout cycle still completes
      do_reset();
      kick();
      repeat (4) @(posedge clk);
      #1 ifu_rvalid = 1'b1;
      #1;
      total++;
      if (state !== 3'd1 || ir_we !== 1'b1) begin
         bad++; $display("FAIL fetch_last_cycle: got st=%0d ir_we=%b expected 1/1", state, ir_we);
      end
      @(posedge clk); #1;
      ifu_rvalid = 1'b0;
      total++;
      if (state !== 3'd2) begin
         bad++; $display("FAIL fetch_late_decode: got %0d expected 2", state);
      end
      // MEM timeout: load whose lsu_done never arrives
      do_reset();
      kick();
      dec_load = 1'b1;
      ifu_rvalid = 1'b1;
      @(posedge clk); #1;
      ifu_rvalid = 1'b0;
      repeat (2 + 5) @(posedge clk);
      #1;
      total++;
      if (state !== 3'd7 || err !== 1'b1 || cycle_cnt !== 64'd8) begin
         bad++; $display("FAIL mem_timeout: got st=%0d err=%b cyc=%0d expected 7/1/8",
                         state, err, cycle_cnt);
      end
   endtask

   task automatic test_ebreak();
      do_reset();
      kick();
      dec_ebreak = 1'b1;
      ifu_rvalid = 1'b1;
      @(posedge clk); #1;
      ifu_rvalid = 1'b0;
      @(posedge clk); #1;
      total++;
      if (state !== 3'd6 || halt !== 1'b1 || instret_cnt !== 64'd1 || cycle_cnt !== 64'd2) begin
         bad++; $display("FAIL ebreak_halt: got st=%0d halt=%b ret=%0d cyc=%0d expected 6/1/1/2",
                         state, halt, instret_cnt, cycle_cnt);
      end
      ifu_rvalid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (flags() !== 8'b0000_0010 || cycle_cnt !== 64'd2 || instret_cnt !== 64'd1) begin
         bad++; $display("FAIL halt_frozen: got flags=%b cyc=%0d ret=%0d expected 00000010/2/1",
                         flags(), cycle_cnt, instret_cnt);
      end
      // illegal has priority over ebreak
      do_reset();
      kick();
      dec_ebreak = 1'b1; dec_illegal = 1'b1;
      ifu_rvalid = 1'b1;
      @(posedge clk); #1;
      ifu_rvalid = 1'b0;
      @(posedge clk); #1;
      total++;
      if (state !== 3'd7 || err !== 1'b1 || instret_cnt !== 64'd0) begin
         bad++; $display("FAIL ebreak_illegal: got st=%0d err=%b ret=%0d expected 7/1/0",
                         state, err, instret_cnt);
      end
      // load and store together is undecodable
      do_reset();
      kick();
      dec_load = 1'b1; dec_store = 1'b1;
      ifu_rvalid = 1'b1;
      @(posedge clk); #1;
      ifu_rvalid = 1'b0;
      @(posedge clk); #1;
      total++;
      if (state !== 3'd7) begin
         bad++; $display("FAIL load_store_conflict: got %0d expected 7", state);
      end
   endtask

   task automatic test_reset_in_mem();
      do_reset();
      kick();
      dec_load = 1'b1;
      ifu_rvalid = 1'b1;
      @(posedge clk); #1;
      ifu_rvalid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (state !== 3'd4 || lsu_req !== 1'b1) begin
         bad++; $display("FAIL pre_reset_mem: got st=%0d lsu_req=%b expected 4/1", state, lsu_req);
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if (state !== 3'd0 || flags() !== 8'h00 || cycle_cnt !== 64'd0 || instret_cnt !== 64'd0) begin
         bad++; $display("FAIL async_reset: got st=%0d flags=%b cyc=%0d ret=%0d expected 0/0/0/0",
                         state, flags(), cycle_cnt, instret_cnt);
      end
      do_reset();
      kick();
      total++;
      if (state !== 3'd1 || cycle_cnt !== 64'd0) begin
         bad++; $display("FAIL resume_fetch: got st=%0d cyc=%0d expected 1/0", state, cycle_cnt);
      end
   endtask

   task automatic test_random_stream();
      do_reset();
      kick();
      for (int n = 0; n < 40; n++)
         run_instr(int'($urandom_range(0, 2)), int'($urandom_range(0, TO)),
                   int'($urandom_range(0, TO)), 1'($urandom_range(0, 1)));
   endtask

   task automatic test_back_to_back();
      do_reset();
      kick();
      run_instr(0, 0, 0, 1'b0);
      run_instr(1, 0, 0, 1'b1);
      run_instr(2, 1, 4, 1'b0);
      run_instr(0, 4, 0, 1'b1);
   endtask

   initial begin
      test_reset();
      test_addi();
      test_load_store();
      test_timeout();
      test_ebreak();
      test_reset_in_mem();
      test_back_to_back();
      test_random_stream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/core_seq_ctrl.md
Name: core_seq_ctrl

Overview:
- Multi-cycle sequencer for the RV64 core datapath: fetch, decode, execute, memory, writeback.
- Drives the instruction-fetch handshake, the load/store handshake, and the IR/PC/register-file write enables.
- Consumes instruction-class flags that the decode unit derives from the held IR.
- Handles halt on ebreak, wait-state timeouts and illegal-instruction error, and keeps cycle/instret counters.

Parameters:
- TIMEOUT, 255, maximum wait cycles in FETCH or MEM before entering ERROR (range 1..65535).
- CNT_W, 64, width of the cycle and instret counters.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  leave IDLE; ignored in all other states
- ifu_req  out  1  instruction fetch request; held high for the whole FETCH state
- ifu_rvalid  in  1  fetch data valid; completes the fetch
- ir_we  out  1  IR load strobe
- dec_load  in  1  held IR is a load
- dec_store  in  1  held IR is a store
- dec_wb  in  1  held IR writes rd
- dec_ebreak  in  1  held IR is ebreak
- dec_illegal  in  1  held IR is not decodable
- lsu_req  out  1  data access request; held high for the whole MEM state
- lsu_wen  out  1  data access is a write
- lsu_done  in  1  data access complete
- rf_we  out  1  register-file write strobe
- pc_we  out  1  PC update strobe
- halt  out  1  core halted by ebreak
- err  out  1  core stopped on error
- state  out  3  current state encoding
- cycle_cnt  out  CNT_W  active cycle count
- instret_cnt  out  CNT_W  retired instruction count

Behaviour:
- Reset: async on rst=1.
  - State goes to IDLE.
  - All 1-bit outputs are 0; both counters and the internal wait counter are 0.
  - Any in-flight fetch or LSU handshake is abandoned; no strobe is issued.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERROR=7. All outputs are decoded from the registered state, so they are Moore-style except where noted.
- IDLE: start=1 moves to FETCH next cycle.
- FETCH:
  - ifu_req=1.
  - If ifu_rvalid=1: ir_we=1 in that same cycle (combinational from ifu_rvalid), then go to DECODE.
  - Otherwise wait_cnt increments.
  - If wait_cnt==TIMEOUT and ifu_rvalid=0, go to ERROR.
  - A handshake that completes on the timeout cycle wins over the timeout.
- DECODE: priority order, evaluated in this cycle:
  1. dec_illegal, or (dec_load and dec_store) → ERROR.
  2. dec_ebreak → HALT; instret_cnt increments (ebreak retires).
  3. Otherwise → EXEC.
- EXEC: exactly one cycle. dec_load or dec_store → MEM; otherwise → WB.
- MEM:
  - lsu_req=1; lsu_wen=dec_store.
  - lsu_done=1 → WB.
  - Timeout rule is identical to FETCH.
- WB: one cycle.
  - pc_we=1.
  - rf_we = dec_wb & ~dec_store.
  - instret_cnt increments.
  - Next state is FETCH.
- HALT, ERROR: terminal until rst.
  - halt=1 in HALT; err=1 in ERROR.
  - No requests or strobes are issued.
- wait_cnt: 16 bits, cleared on every transition into FETCH or MEM.
- dec_* inputs must be stable from DECODE through WB, because the IR is held. They are ignored in all other states.
- cycle_cnt increments every cycle the state is FETCH through WB. It is frozen in IDLE, HALT and ERROR.
- Both counters wrap modulo 2^CNT_W with no flag.
- Nominal latency, with the handshake completing in its first cycle:
  - ALU instruction: 4 cycles (F, D, E, W).
  - Load or store: 5 cycles (F, D, E, M, W).

Test Plan:
- Reset, start=1, then addi with ifu_rvalid=1 in the first FETCH cycle and dec_wb=1:
  - States 1,2,3,5 then 1.
  - ir_we pulses in cycle 1; rf_we and pc_we pulse in cycle 4.
  - instret_cnt=1, cycle_cnt=4.
- ld with lsu_done delayed 3 cycles:
  - lsu_req high for 4 cycles, lsu_wen=0.
  - rf_we=1 in WB; total of 8 active cycles.
- sd with dec_wb=1 and lsu_done immediate: lsu_wen=1, rf_we stays 0 in WB, pc_we=1.
- TIMEOUT=4 with ifu_rvalid held low:
  - ERROR after 5 FETCH cycles; err=1, state=7.
  - A later ifu_rvalid is ignored.
  - Repeat with ifu_rvalid on the 5th FETCH cycle: reaches DECODE.
- dec_ebreak=1 with dec_illegal=0:
  - HALT; halt=1, instret_cnt increments, cycle_cnt frozen.
  - dec_ebreak and dec_illegal both 1: ERROR.
- Assert rst during MEM with lsu_req=1:
  - All outputs 0 immediately (asynchronously), state=0, counters 0.
  - start=1 later resumes at FETCH.
